ds_decim: RTL and testbench
===========================

DS_DECIM -- requirements
Module: ds_decim

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: output sample width in bits.
REQ-002 The block SHALL have parameter DEC_LOG2, default 8: log2 of the decimation ratio, so R = 2^DEC_LOG2.
REQ-003 Parameters SHALL satisfy DEC_LOG2 >= 1 and 2*DEC_LOG2 >= DATA_W; elaboration SHALL fail otherwise.
REQ-004 Port dec_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port dec_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port dec_en, input, 1 bit: when high, dec_din is accepted on this edge.
REQ-007 Port dec_din, input, 1 bit: delta-sigma bitstream, 1 = +1 and 0 = 0 (unsigned density).
REQ-008 Port dec_dout, output, DATA_W bits: decimated unsigned sample.
REQ-009 Port dec_valid, output, 1 bit: one-cycle strobe marking a new dec_dout.

Function
REQ-010 The block SHALL implement a 2nd-order CIC (sinc^2) decimator with ratio R; internal width W = 2*DEC_LOG2+1.
REQ-011 On each edge with dec_en=1: integ1 <= integ1 + dec_din; integ2 <= integ2 + integ1 (pre-update integ1); all arithmetic modulo 2^W, and wrap-around is legal and required.
REQ-012 On each edge with dec_en=0, the integrators and the decimation counter SHALL hold.
REQ-013 Decimation counter: DEC_LOG2 bits; it SHALL increment on each accepted bit and wrap from R-1 to 0.
REQ-014 A decimation event SHALL occur on the edge where dec_en=1 and the counter = R-1; it SHALL register dec_pend=1 for one cycle.
REQ-015 On the edge with dec_pend=1: c1 = integ2 - integ2_prev; c2 = c1 - c1_prev (mod 2^W); integ2_prev <= integ2; c1_prev <= c1.
REQ-016 On the same edge: dec_dout <= min(c2 >> (2*DEC_LOG2 - DATA_W), 2^DATA_W - 1), and dec_valid <= 1.
REQ-017 dec_valid SHALL be high for exactly one cycle per decimation event; latency is 1 cycle from the decimation edge to the dec_valid rising edge.
REQ-018 dec_dout SHALL hold its value between strobes.
REQ-019 The full-scale input (all ones) gives c2 = R^2. This SHALL saturate to 2^DATA_W - 1 when 2*DEC_LOG2 = DATA_W.
REQ-020 The first two samples after reset are start-up transients; they SHALL still strobe dec_valid. From the third sample on, the output SHALL be exact for a periodic input.
REQ-021 A decimation event while dec_pend=1 cannot occur (R >= 2), so no collision handling is needed.

Reset
REQ-022 dec_rst=1 SHALL asynchronously clear integ1, integ2, integ2_prev, c1_prev, the counter, dec_pend, dec_dout (0) and dec_valid (0).
REQ-023 Reset asserted mid-frame SHALL discard the partial frame. No dec_valid SHALL appear until R new accepted bits after deassertion.

Structure
REQ-024 Constants DS_DATA_W=16 and DS_DEC_LOG2=8 SHALL live in shared package ds_pkg, which is also used by the modulator side.
REQ-025 One sub-module, ds_integrator (W-bit enabled modulo accumulator with async reset), SHALL be instantiated twice. Comb, counter and output logic SHALL stay in ds_decim.

Verification (DATA_W=16, DEC_LOG2=8)
REQ-026 All-zeros stream, dec_en=1 -> every dec_valid strobe every 256 cycles has dec_dout=0.
REQ-027 All-ones stream -> from the 3rd strobe, dec_dout=65535 (saturated). The 1st strobe shows 32896 (sum_{k=1..256} k / 1 transient = 256*257/2).
REQ-028 Alternating 1,0 stream -> from the 3rd strobe, dec_dout=32768 exactly.
REQ-029 Loopback with the team's first-order delta-sigma modulator, din=0x4000, dec_en=1 -> from the 3rd strobe, dec_dout in 16384±2.
REQ-030 dec_en toggled 1/0 each cycle with all-ones input -> strobes every 512 cycles, with the same values as REQ-027.
REQ-031 dec_rst pulsed at accepted bit 100 of a frame -> dec_dout=0 and dec_valid=0 immediately; the next strobe comes exactly 256 accepted bits (+1 cycle) after release.

Source files
------------

// File: rtl/ds_pkg.sv
// ds_pkg -- constants and helpers shared by the delta-sigma decimator and modulator.
//
//   DS_DATA_W   : decimated sample width in bits
//   DS_DEC_LOG2 : log2 of the decimation ratio R
//   ds_int_w()  : internal CIC width for a given ratio (2*log2(R) + 1)
package ds_pkg;

  localparam int unsigned DS_DATA_W   = 16;
  localparam int unsigned DS_DEC_LOG2 = 8;

  // A sinc^2 stage of ratio R can produce values up to R^2 = 2^(2*log2 R),
  // which needs one bit more than 2*log2(R).
  function automatic int unsigned ds_int_w(input int unsigned dec_log2);
    return 2 * dec_log2 + 1;
  endfunction

endpackage

// File: rtl/ds_integrator.sv
// ds_integrator -- W-bit modulo accumulator with enable and asynchronous reset.
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset, clears the accumulator
//   en_i   : when high, add_i is accumulated on this edge; otherwise hold
//   add_i  : W-bit addend
//   acc_o  : current accumulator value (registered)
//
// Overflow wraps modulo 2^W on purpose: the CIC combs downstream undo the wrap.
module ds_integrator
  import ds_pkg::*;
#(
  parameter int unsigned W = ds_int_w(DS_DEC_LOG2)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] add_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = acc_q + add_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/ds_decim.sv
// ds_decim -- 2nd-order CIC (sinc^2) decimator for a 1-bit delta-sigma stream.
//
// Parameters:
//   DATA_W   : output sample width
//   DEC_LOG2 : log2 of the decimation ratio R (R = 2^DEC_LOG2)
//
// Ports:
//   dec_clk   : clock, rising edge
//   dec_rst   : asynchronous active-high reset
//   dec_en    : input bit accepted on this edge when high
//   dec_din   : bitstream, 1 = +1, 0 = 0
//   dec_dout  : decimated unsigned sample, held between strobes
//   dec_valid : one-cycle strobe, one cycle after each frame's last accepted bit
//
// Two integrators run at the input rate; every R accepted bits a decimation
// event is registered (pend_q) and on the following edge the two combs run and
// the saturated, scaled result is registered onto dec_dout.
module ds_decim
  import ds_pkg::*;
#(
  parameter int unsigned DATA_W   = DS_DATA_W,
  parameter int unsigned DEC_LOG2 = DS_DEC_LOG2
) (
  input  logic              dec_clk,
  input  logic              dec_rst,
  input  logic              dec_en,
  input  logic              dec_din,
  output logic [DATA_W-1:0] dec_dout,
  output logic              dec_valid
);

  localparam int unsigned W     = ds_int_w(DEC_LOG2);
  localparam int unsigned Shift = 2 * DEC_LOG2 - DATA_W;

  localparam logic [DEC_LOG2-1:0] CntLast = '1;
  localparam logic [W-1:0]        SatMax  = {{(W - DATA_W){1'b0}}, {DATA_W{1'b1}}};

  if (DEC_LOG2 < 1 || 2 * DEC_LOG2 < DATA_W) begin : g_bad_params
    $error("ds_decim: parameters require DEC_LOG2 >= 1 and 2*DEC_LOG2 >= DATA_W");
  end

  // ---------------------------------------------------------------------------
  // Integrators
  // ---------------------------------------------------------------------------
  logic [W-1:0] din_ext;
  logic [W-1:0] integ1;
  logic [W-1:0] integ2;

  assign din_ext = W'(dec_din);

  ds_integrator #(
    .W(W)
  ) u_integ1 (
    .clk_i (dec_clk),
    .rst_i (dec_rst),
    .en_i  (dec_en),
    .add_i (din_ext),
    .acc_o (integ1)
  );

  // Accumulates the pre-update value of integ1, so integ2 lags one bit behind.
  ds_integrator #(
    .W(W)
  ) u_integ2 (
    .clk_i (dec_clk),
    .rst_i (dec_rst),
    .en_i  (dec_en),
    .add_i (integ1),
    .acc_o (integ2)
  );

  // integ2 + integ1 is the second integrator's output including every bit
  // accepted so far. Using it as the comb input makes the frame sum independent
  // of whether dec_en happens to be high on the comb edge, and keeps the first
  // sample equal to sum_{k=1..R} k for a full-scale input.
  logic [W-1:0] tap;
  assign tap = integ2 + integ1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DEC_LOG2-1:0] cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [W-1:0]        tap_prev_q, tap_prev_d;
  logic [W-1:0]        c1_prev_q, c1_prev_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                valid_q, valid_d;

  // ---------------------------------------------------------------------------
  // Combs and output scaling
  // ---------------------------------------------------------------------------
  logic [W-1:0]      c1;
  logic [W-1:0]      c2;
  logic [W-1:0]      c2_scaled;
  logic [DATA_W-1:0] sample;

  // Modulo differences: wrap in the integrators cancels here.
  assign c1        = tap - tap_prev_q;
  assign c2        = c1 - c1_prev_q;
  assign c2_scaled = c2 >> Shift;
  // Full scale gives exactly R^2, one past the largest code; clamp it.
  assign sample    = (c2_scaled > SatMax) ? {DATA_W{1'b1}} : c2_scaled[DATA_W-1:0];

  always_comb begin
    cnt_d      = cnt_q;
    pend_d     = 1'b0;
    tap_prev_d = tap_prev_q;
    c1_prev_d  = c1_prev_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;

    if (dec_en) begin
      cnt_d  = cnt_q + DEC_LOG2'(1);
      pend_d = (cnt_q == CntLast);
    end

    // R >= 2 guarantees a new event never lands while pend_q is still set.
    if (pend_q) begin
      tap_prev_d = tap;
      c1_prev_d  = c1;
      dout_d     = sample;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge dec_clk or posedge dec_rst) begin
    if (dec_rst) begin
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      tap_prev_q <= '0;
      c1_prev_q  <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      tap_prev_q <= tap_prev_d;
      c1_prev_q  <= c1_prev_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
    end
  end

  assign dec_dout  = dout_q;
  assign dec_valid = valid_q;

endmodule

// File: tb/tb_ds_decim.sv
// tb_ds_decim -- self-checking bench for ds_decim (DATA_W=16, DEC_LOG2=8).
// A frame-level model (prefix sums of the accepted bits, second difference of
// the per-frame totals) predicts dec_valid/dec_dout every cycle; directed
// scenarios add literal expectations for known streams.
module tb_ds_decim;
  import ds_pkg::*;

  localparam int unsigned DATA_W   = DS_DATA_W;
  localparam int unsigned DEC_LOG2 = DS_DEC_LOG2;
  localparam int          R        = 1 << DEC_LOG2;
  localparam int          W        = 2 * DEC_LOG2 + 1;
  localparam int          SH       = 2 * DEC_LOG2 - DATA_W;
  localparam longint      MAXCODE  = (64'sd1 << DATA_W) - 1;
  localparam longint      WMASK    = (64'sd1 << W) - 1;

  logic              dec_clk = 1'b0;
  logic              dec_rst = 1'b1;
  logic              dec_en  = 1'b0;
  logic              dec_din = 1'b0;
  logic [DATA_W-1:0] dec_dout;
  logic              dec_valid;

  ds_decim #(
    .DATA_W   (DATA_W),
    .DEC_LOG2 (DEC_LOG2)
  ) dut (
    .dec_clk   (dec_clk),
    .dec_rst   (dec_rst),
    .dec_en    (dec_en),
    .dec_din   (dec_din),
    .dec_dout  (dec_dout),
    .dec_valid (dec_valid)
  );

  always #5 dec_clk = ~dec_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo,
                             input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  longint m_p = 0;   // ones seen so far
  longint m_s = 0;   // sum of m_p over all accepted bits
  longint m_s1 = 0;  // m_s at the previous frame end
  longint m_s2 = 0;  // m_s two frame ends ago
  int     m_cnt = 0;
  int     m_nframes = 0;
  bit     due = 1'b0;
  longint due_val = 0;
  bit     exp_valid = 1'b0;
  longint exp_dout = 0;
  int     cyc = 0;

  // Sinc^2 output = second difference of the frame-end totals, taken mod 2^W,
  // scaled and clamped to the output range.
  function automatic longint sample_of(input longint c2);
    longint v;
    v = (c2 & WMASK) >>> SH;
    return (v > MAXCODE) ? MAXCODE : v;
  endfunction

  always @(posedge dec_clk or posedge dec_rst) begin
    if (dec_rst) begin
      m_p = 0; m_s = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0;
      due = 1'b0; exp_valid = 1'b0; exp_dout = 0;
    end else begin
      exp_valid = due;
      if (due) exp_dout = due_val;
      due = 1'b0;
      if (dec_en) begin
        m_p += longint'(dec_din);
        m_s += m_p;
        m_cnt++;
        if (m_cnt == R) begin
          m_cnt   = 0;
          due     = 1'b1;
          due_val = sample_of(m_s - 2 * m_s1 + m_s2);
          m_s2    = m_s1;
          m_s1    = m_s;
          m_nframes++;
        end
      end
    end
  end

  always @(posedge dec_clk) cyc++;

  // ---------------------------------------------------------------------------
  // Compare + strobe capture (opposite edge)
  // ---------------------------------------------------------------------------
  longint strobe_q[$];
  int     strobe_cyc[$];

  always @(negedge dec_clk) begin
    if (!dec_rst) begin
      check("valid_vs_model", longint'(dec_valid), longint'(exp_valid));
      check("dout_vs_model", longint'(dec_dout), exp_dout);
      if (dec_valid) begin
        strobe_q.push_back(longint'(dec_dout));
        strobe_cyc.push_back(cyc);
      end
    end
  end

  function automatic longint strobe_at(input int i);
    return (i < strobe_q.size()) ? strobe_q[i] : -1;
  endfunction

  function automatic int gap_at(input int i);
    return (i + 1 < strobe_cyc.size()) ? strobe_cyc[i+1] - strobe_cyc[i] : -1;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int          pat_idx = 0;
  logic [15:0] mod_acc = '0;

  // mode: 0 zeros, 1 ones, 2 alternating 1/0, 3 first-order DS of 0x4000, 4 random
  // en_mode: 0 always, 1 toggle starting high, 2 random ~70 %
  task automatic drive(input int mode, input int en_mode, input int ncyc);
    logic        en;
    logic        b;
    logic [16:0] sum;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge dec_clk);
      #1;
      case (en_mode)
        0:       en = 1'b1;
        1:       en = (i % 2 == 0);
        default: en = ($urandom_range(0, 99) < 70);
      endcase
      b = 1'($urandom);
      if (en) begin
        case (mode)
          0: b = 1'b0;
          1: b = 1'b1;
          2: b = (pat_idx % 2 == 0);
          3: begin
            sum     = {1'b0, mod_acc} + 17'h04000;
            mod_acc = sum[15:0];
            b       = sum[16];
          end
          default: b = 1'($urandom);
        endcase
        pat_idx++;
      end
      dec_en  = en;
      dec_din = b;
    end
  endtask

  task automatic clear_capture();
    strobe_q.delete();
    strobe_cyc.delete();
    pat_idx   = 0;
    mod_acc   = '0;
    m_nframes = 0;
  endtask

  task automatic do_reset();
    @(negedge dec_clk);
    #2;
    dec_rst = 1'b1;
    dec_en  = 1'b0;
    dec_din = 1'b0;
    @(negedge dec_clk);
    #2;
    dec_rst = 1'b0;
    clear_capture();
  endtask

  int rel_cyc;

  initial begin
    // Reset state
    #12;
    check("reset_dout", longint'(dec_dout), 0);
    check("reset_valid", longint'(dec_valid), 0);
    @(negedge dec_clk);
    #2;
    dec_rst = 1'b0;
    clear_capture();

    // All zeros
    drive(0, 0, 4 * R + 4);
    check("zeros_nstrobes", strobe_q.size(), 4);
    for (int i = 0; i < 4; i++) check("zeros_value", strobe_at(i), 0);

    // All ones: 256*257/2 first, saturated from then on
    do_reset();
    drive(1, 0, 4 * R + 4);
    check("ones_nstrobes", strobe_q.size(), 4);
    check("ones_first", strobe_at(0), 32896);
    check("ones_third", strobe_at(2), 65535);
    check("ones_fourth", strobe_at(3), 65535);
    check("ones_period", gap_at(0), R);

    // Alternating 1,0: half scale exactly
    do_reset();
    drive(2, 0, 4 * R + 4);
    check("alt_third", strobe_at(2), 32768);
    check("alt_fourth", strobe_at(3), 32768);

    // First-order modulator loopback, input 0x4000
    do_reset();
    drive(3, 0, 5 * R + 4);
    check("mod_nstrobes", strobe_q.size(), 5);
    for (int i = 2; i < 5; i++) check_range("mod_value", strobe_at(i), 16382, 16386);

    // dec_en toggling: half rate, same values as continuous all-ones
    do_reset();
    drive(1, 1, 3 * 2 * R + 4);
    check("toggle_nstrobes", strobe_q.size(), 3);
    check("toggle_first", strobe_at(0), 32896);
    check("toggle_third", strobe_at(2), 65535);
    check("toggle_period", gap_at(0), 2 * R);

    // Reset 100 bits into the second frame
    do_reset();
    drive(1, 0, R + 100);
    check("prerst_dout", longint'(dec_dout), 32896);
    @(negedge dec_clk);
    #2;
    dec_rst = 1'b1;
    #1;
    check("midrst_dout", longint'(dec_dout), 0);
    check("midrst_valid", longint'(dec_valid), 0);
    @(negedge dec_clk);
    #1;
    clear_capture();
    dec_en  = 1'b1;
    dec_din = 1'b1;
    dec_rst = 1'b0;
    rel_cyc = cyc;
    drive(1, 0, R + 10);
    check("postrst_nstrobes", strobe_q.size(), 1);
    check("postrst_latency", (strobe_cyc.size() > 0) ? strobe_cyc[0] - rel_cyc : -1, R + 1);
    check("postrst_value", strobe_at(0), 32896);

    // Random bits with random enable; every cycle is checked against the model
    do_reset();
    drive(4, 2, 10 * R);
    @(negedge dec_clk);
    @(negedge dec_clk);
    check("rand_strobe_count", strobe_q.size(), m_nframes);
    check_range("rand_frames_seen", m_nframes, 5, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
